// File: rtl/mask_frame_analyzer.sv
// mask_frame_analyzer
// Scans a binary threshold mask held in BRAM (one row per address, bit x =
// column x) after each frame-done rising edge. It produces the set-pixel
// count and the bounding box of set pixels for the frame.
// Optional build macro: MASK_CENTROID_EN adds sum_x / sum_y outputs, which
// are the per-frame sums of the column and row indices of set pixels.
module mask_frame_analyzer #(
  parameter int ROW_W   = 640,
  parameter int MAX_ROW = 480,
  parameter int CHUNK_W = 32,
  parameter int RD_LAT  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_done_in,
  output logic [8:0]       mask_addr,
  output logic             mask_en,
  input  logic [ROW_W-1:0] mask_dout,
  output logic             busy,
  output logic             result_valid,
  output logic [18:0]      pix_count,
  output logic [9:0]       min_x,
  output logic [9:0]       max_x,
  output logic [8:0]       min_y,
  output logic [8:0]       max_y,
  output logic             mask_empty,
  output logic             frame_drop
`ifdef MASK_CENTROID_EN
  ,
  output logic [27:0]      sum_x,
  output logic [27:0]      sum_y
`endif
);

  localparam int NCHUNK = ROW_W / CHUNK_W;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IW     = (CHUNK_W > 1) ? $clog2(CHUNK_W) : 1;
  localparam int PW     = $clog2(CHUNK_W + 1);
  localparam int LW     = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SCAN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Scan bookkeeping
  logic [8:0]       row_q, row_d;
  logic [CW-1:0]    chunk_q, chunk_d;
  logic [LW-1:0]    lat_q, lat_d;
  logic [ROW_W-1:0] row_buf_q, row_buf_d;

  // Running accumulators for the frame in progress
  logic [18:0] acc_cnt_q, acc_cnt_d;
  logic [9:0]  acc_minx_q, acc_minx_d;
  logic [9:0]  acc_maxx_q, acc_maxx_d;
  logic [8:0]  acc_miny_q, acc_miny_d;
  logic [8:0]  acc_maxy_q, acc_maxy_d;

  // Published results, which change only when a scan completes
  logic [18:0] res_cnt_q, res_cnt_d;
  logic [9:0]  res_minx_q, res_minx_d;
  logic [9:0]  res_maxx_q, res_maxx_d;
  logic [8:0]  res_miny_q, res_miny_d;
  logic [8:0]  res_maxy_q, res_maxy_d;
  logic        res_empty_q, res_empty_d;

  // Handshake / status flags
  logic fdi_q;
  logic pend_q, pend_d;
  logic busy_q, busy_d;
  logic valid_q, valid_d;
  logic drop_q, drop_d;
  logic start;

`ifdef MASK_CENTROID_EN
  logic [27:0] acc_sx_q, acc_sx_d;
  logic [27:0] acc_sy_q, acc_sy_d;
  logic [27:0] res_sx_q, res_sx_d;
  logic [27:0] res_sy_q, res_sy_d;
  logic [15:0] ch_isum;
  logic [27:0] ch_sx, ch_sy;
`endif

  // Per-chunk analysis
  logic [CHUNK_W-1:0] chunk_bits;
  logic [9:0]         chunk_base;
  logic [PW-1:0]      ch_pop;
  logic               ch_any;
  logic [IW-1:0]      ch_lo, ch_hi;
  logic [9:0]         col_lo, col_hi;

  assign start      = frame_done_in & ~fdi_q;
  assign chunk_base = 10'(int'(chunk_q) * CHUNK_W);
  assign chunk_bits = row_buf_q[chunk_base +: CHUNK_W];
  assign col_lo     = chunk_base + 10'(ch_lo);
  assign col_hi     = chunk_base + 10'(ch_hi);

  // Popcount plus the lowest and highest set bit of the current chunk
  always_comb begin
    ch_pop = '0;
    ch_any = 1'b0;
    ch_lo  = '0;
    ch_hi  = '0;
`ifdef MASK_CENTROID_EN
    ch_isum = '0;
`endif
    for (int i = 0; i < CHUNK_W; i++) begin
      if (chunk_bits[i]) begin
        ch_pop = ch_pop + PW'(1);
        ch_hi  = IW'(i);
        if (!ch_any) ch_lo = IW'(i);
        ch_any = 1'b1;
`ifdef MASK_CENTROID_EN
        ch_isum = ch_isum + 16'(i);
`endif
      end
    end
  end

`ifdef MASK_CENTROID_EN
  // Column sum of a chunk = pop * base + sum of in-chunk offsets
  assign ch_sx = 28'(ch_pop) * 28'(chunk_base) + 28'(ch_isum);
  assign ch_sy = 28'(ch_pop) * 28'(row_q);
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath next values
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    chunk_d     = chunk_q;
    lat_d       = lat_q;
    row_buf_d   = row_buf_q;
    acc_cnt_d   = acc_cnt_q;
    acc_minx_d  = acc_minx_q;
    acc_maxx_d  = acc_maxx_q;
    acc_miny_d  = acc_miny_q;
    acc_maxy_d  = acc_maxy_q;
    res_cnt_d   = res_cnt_q;
    res_minx_d  = res_minx_q;
    res_maxx_d  = res_maxx_q;
    res_miny_d  = res_miny_q;
    res_maxy_d  = res_maxy_q;
    res_empty_d = res_empty_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    drop_d      = 1'b0;
    pend_d      = 1'b0;
`ifdef MASK_CENTROID_EN
    acc_sx_d    = acc_sx_q;
    acc_sy_d    = acc_sy_q;
    res_sx_d    = res_sx_q;
    res_sy_d    = res_sy_q;
`endif

    case (state_q)
      S_IDLE: begin
        // A start seen during the previous DONE cycle is honoured here
        if (start || pend_q) begin
          acc_cnt_d  = '0;
          acc_minx_d = 10'd1023;
          acc_maxx_d = '0;
          acc_miny_d = 9'd511;
          acc_maxy_d = '0;
`ifdef MASK_CENTROID_EN
          acc_sx_d   = '0;
          acc_sy_d   = '0;
`endif
          row_d      = '0;
          busy_d     = 1'b1;
          state_d    = S_READ;
        end
      end

      S_READ: begin
        lat_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (lat_q == LW'(RD_LAT)) begin
          row_buf_d = mask_dout;
          chunk_d   = '0;
          state_d   = S_SCAN;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end

      S_SCAN: begin
        acc_cnt_d = acc_cnt_q + 19'(ch_pop);
`ifdef MASK_CENTROID_EN
        acc_sx_d  = acc_sx_q + ch_sx;
        acc_sy_d  = acc_sy_q + ch_sy;
`endif
        if (ch_any) begin
          if (col_lo < acc_minx_q) acc_minx_d = col_lo;
          if (col_hi > acc_maxx_q) acc_maxx_d = col_hi;
          if (row_q < acc_miny_q)  acc_miny_d = row_q;
          if (row_q > acc_maxy_q)  acc_maxy_d = row_q;
        end
        if (chunk_q == CW'(NCHUNK - 1)) begin
          if (row_q == 9'(MAX_ROW - 1)) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + 9'd1;
            state_d = S_READ;
          end
        end else begin
          chunk_d = chunk_q + CW'(1);
        end
      end

      S_DONE: begin
        res_cnt_d = acc_cnt_q;
`ifdef MASK_CENTROID_EN
        res_sx_d  = acc_sx_q;
        res_sy_d  = acc_sy_q;
`endif
        if (acc_cnt_q == '0) begin
          res_minx_d  = '0;
          res_maxx_d  = '0;
          res_miny_d  = '0;
          res_maxy_d  = '0;
          res_empty_d = 1'b1;
        end else begin
          res_minx_d  = acc_minx_q;
          res_maxx_d  = acc_maxx_q;
          res_miny_d  = acc_miny_q;
          res_maxy_d  = acc_maxy_q;
          res_empty_d = 1'b0;
        end
        valid_d = 1'b1;
        busy_d  = 1'b0;
        pend_d  = start;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // An edge mid-scan is dropped; the DONE cycle instead latches it as pending
    if (start && (state_q == S_READ || state_q == S_WAIT || state_q == S_SCAN))
      drop_d = 1'b1;
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fdi_q       <= 1'b0;
      pend_q      <= 1'b0;
      row_q       <= '0;
      chunk_q     <= '0;
      lat_q       <= '0;
      row_buf_q   <= '0;
      acc_cnt_q   <= '0;
      acc_minx_q  <= '0;
      acc_maxx_q  <= '0;
      acc_miny_q  <= '0;
      acc_maxy_q  <= '0;
      res_cnt_q   <= '0;
      res_minx_q  <= '0;
      res_maxx_q  <= '0;
      res_miny_q  <= '0;
      res_maxy_q  <= '0;
      res_empty_q <= 1'b1;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      drop_q      <= 1'b0;
`ifdef MASK_CENTROID_EN
      acc_sx_q    <= '0;
      acc_sy_q    <= '0;
      res_sx_q    <= '0;
      res_sy_q    <= '0;
`endif
    end else begin
      fdi_q       <= frame_done_in;
      pend_q      <= pend_d;
      row_q       <= row_d;
      chunk_q     <= chunk_d;
      lat_q       <= lat_d;
      row_buf_q   <= row_buf_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_minx_q  <= acc_minx_d;
      acc_maxx_q  <= acc_maxx_d;
      acc_miny_q  <= acc_miny_d;
      acc_maxy_q  <= acc_maxy_d;
      res_cnt_q   <= res_cnt_d;
      res_minx_q  <= res_minx_d;
      res_maxx_q  <= res_maxx_d;
      res_miny_q  <= res_miny_d;
      res_maxy_q  <= res_maxy_d;
      res_empty_q <= res_empty_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      drop_q      <= drop_d;
`ifdef MASK_CENTROID_EN
      acc_sx_q    <= acc_sx_d;
      acc_sy_q    <= acc_sy_d;
      res_sx_q    <= res_sx_d;
      res_sy_q    <= res_sy_d;
`endif
    end
  end

  // row_q only changes on entry to READ, so the address holds between reads
  assign mask_addr    = row_q;
  assign mask_en      = (state_q == S_READ);
  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign pix_count    = res_cnt_q;
  assign min_x        = res_minx_q;
  assign max_x        = res_maxx_q;
  assign min_y        = res_miny_q;
  assign max_y        = res_maxy_q;
  assign mask_empty   = res_empty_q;
  assign frame_drop   = drop_q;
`ifdef MASK_CENTROID_EN
  assign sum_x        = res_sx_q;
  assign sum_y        = res_sy_q;
`endif

endmodule

// File: tb/tb_mask_frame_analyzer.sv
// Testbench for mask_frame_analyzer: table-driven frames plus hand-written
// sequences for reset abort, a start edge during DONE and a dropped start.
module tb_mask_frame_analyzer;

  localparam int FRAME_LAT = 480 * 23 + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         frame_done_in = 1'b0;
  logic [8:0]   mask_addr;
  logic         mask_en;
  logic [639:0] mask_dout = '0;
  logic         busy, result_valid, mask_empty, frame_drop;
  logic [18:0]  pix_count;
  logic [9:0]   min_x, max_x;
  logic [8:0]   min_y, max_y;
`ifdef MASK_CENTROID_EN
  logic [27:0]  sum_x, sum_y;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int rv_cnt = 0, drop_cnt = 0, addr_bad = 0;

  logic [639:0] mem [0:479];

  mask_frame_analyzer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_done_in (frame_done_in),
    .mask_addr     (mask_addr),
    .mask_en       (mask_en),
    .mask_dout     (mask_dout),
    .busy          (busy),
    .result_valid  (result_valid),
    .pix_count     (pix_count),
    .min_x         (min_x),
    .max_x         (max_x),
    .min_y         (min_y),
    .max_y         (max_y),
    .mask_empty    (mask_empty),
    .frame_drop    (frame_drop)
`ifdef MASK_CENTROID_EN
    ,
    .sum_x         (sum_x),
    .sum_y         (sum_y)
`endif
  );

  always #5 clk = ~clk;

  // One-cycle-latency BRAM read port
  always @(posedge clk) if (mask_en) mask_dout <= mem[mask_addr];

  // Event monitors
  always @(negedge clk) begin
    if (result_valid) rv_cnt++;
    if (frame_drop) drop_cnt++;
    if (mask_en && mask_addr > 9'd479) addr_bad++;
  end

  typedef struct {
    string           name;
    bit              all_ones;
    int              npts;
    logic [3:0][9:0] px;
    logic [3:0][8:0] py;
    int              cnt, mnx, mxx, mny, mxy;
    bit              empty;
    int              sx, sy;
  } vec_t;

  function automatic vec_t mkv(string n, bit all, int np,
                               int x0, int y0, int x1, int y1,
                               int x2, int y2, int x3, int y3,
                               int c, int mnx, int mxx, int mny, int mxy,
                               bit e, int sx, int sy);
    vec_t v;
    v.name = n; v.all_ones = all; v.npts = np;
    v.px[0] = 10'(x0); v.py[0] = 9'(y0);
    v.px[1] = 10'(x1); v.py[1] = 9'(y1);
    v.px[2] = 10'(x2); v.py[2] = 9'(y2);
    v.px[3] = 10'(x3); v.py[3] = 9'(y3);
    v.cnt = c; v.mnx = mnx; v.mxx = mxx; v.mny = mny; v.mxy = mxy;
    v.empty = e; v.sx = sx; v.sy = sy;
    return v;
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic load_pattern(input vec_t v);
    for (int y = 0; y < 480; y++) mem[y] = v.all_ones ? {640{1'b1}} : '0;
    for (int i = 0; i < v.npts; i++) mem[v.py[i]][v.px[i]] = 1'b1;
  endtask

  task automatic check_results(input vec_t v);
    check({v.name, ".pix_count"}, pix_count, v.cnt);
    check({v.name, ".min_x"}, min_x, v.mnx);
    check({v.name, ".max_x"}, max_x, v.mxx);
    check({v.name, ".min_y"}, min_y, v.mny);
    check({v.name, ".max_y"}, max_y, v.mxy);
    check({v.name, ".mask_empty"}, mask_empty, v.empty);
`ifdef MASK_CENTROID_EN
    check({v.name, ".sum_x"}, sum_x, v.sx);
    check({v.name, ".sum_y"}, sum_y, v.sy);
`endif
    $display("[TB] frame %s: count=%0d x %0d..%0d y %0d..%0d empty=%0b",
             v.name, pix_count, min_x, max_x, min_y, max_y, mask_empty);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".result_valid"}, result_valid, 0);
    check({tag, ".pix_count"}, pix_count, 0);
    check({tag, ".bbox_or"}, min_x | max_x | 10'(min_y) | 10'(max_y), 0);
    check({tag, ".mask_empty"}, mask_empty, 1);
    check({tag, ".frame_drop"}, frame_drop, 0);
    check({tag, ".mask_en"}, mask_en, 0);
    check({tag, ".mask_addr"}, mask_addr, 0);
`ifdef MASK_CENTROID_EN
    check({tag, ".sums"}, sum_x | sum_y, 0);
`endif
    $display("[TB] reset check %s done", tag);
  endtask

  // Raise a fresh start edge and count posedges until result_valid (-1 on timeout)
  task automatic run_frame(output int lat);
    frame_done_in = 1'b0;
    repeat (3) @(negedge clk);
    frame_done_in = 1'b1;
    lat = 0;
    while (lat < FRAME_LAT + 1000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (result_valid) break;
    end
    if (!result_valid) lat = -1;
  endtask

  vec_t vecs[4];
  vec_t vx, vy;
  int   lat, n, rv_before, drop_before;
  logic [18:0] held_cnt;

  initial begin
    vecs[0] = mkv("zero",   0, 0, 0,0, 0,0, 0,0, 0,0,
                  0, 0, 0, 0, 0, 1, 0, 0);
    vecs[1] = mkv("single", 0, 1, 37,100, 0,0, 0,0, 0,0,
                  1, 37, 37, 100, 100, 0, 37, 100);
    vecs[2] = mkv("ones",   1, 0, 0,0, 0,0, 0,0, 0,0,
                  307200, 0, 639, 0, 479, 0, 98150400, 73574400);
    vecs[3] = mkv("bound",  0, 4, 0,0, 639,479, 31,320, 32,320,
                  4, 0, 639, 0, 479, 0, 702, 1119);
    vx = mkv("postrst", 0, 2, 5,10, 600,300, 0,0, 0,0,
             2, 5, 600, 10, 300, 0, 605, 310);
    vy = mkv("pending", 0, 2, 639,0, 31,479, 0,0, 0,0,
             2, 31, 639, 0, 479, 0, 670, 479);

    // Reset state
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven full frames
    for (int i = 0; i < 4; i++) begin
      load_pattern(vecs[i]);
      run_frame(lat);
      check({vecs[i].name, ".latency"}, lat, FRAME_LAT);
      check({vecs[i].name, ".busy_at_valid"}, busy, 0);
      check_results(vecs[i]);
      held_cnt = pix_count;
      repeat (3) @(negedge clk);
      check({vecs[i].name, ".valid_pulse"}, result_valid, 0);
      check({vecs[i].name, ".held"}, pix_count, held_cnt);
    end

    // Reset asserted while row 200 is being read aborts the scan
    load_pattern(vecs[1]);
    frame_done_in = 1'b0;
    repeat (3) @(negedge clk);
    frame_done_in = 1'b1;
    n = 0;
    while (n < 6000 && !(mask_en && mask_addr == 9'd200)) begin
      @(negedge clk);
      n++;
    end
    check("abort.reached_row200", (n < 6000) ? 1 : 0, 1);
    check("abort.busy_before", busy, 1);
    rv_before = rv_cnt;
    rst_n = 1'b0;
    #1;
    check_reset("abort");
    frame_done_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort.no_valid", rv_cnt - rv_before, 0);
    check("abort.idle", busy, 0);

    // Fresh frame after reset; a start edge lands exactly in its DONE cycle
    load_pattern(vx);
    rv_before = rv_cnt;
    drop_before = drop_cnt;
    frame_done_in = 1'b1;
    lat = 0;
    while (lat < FRAME_LAT + 1000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 10) frame_done_in = 1'b0;
      if (lat == FRAME_LAT - 1) frame_done_in = 1'b1;
      if (result_valid) break;
    end
    check("postrst.latency", lat, FRAME_LAT);
    check_results(vx);
    check("done_edge.no_drop", drop_cnt - drop_before, 0);

    // Pending scan reads the new pattern; a second edge mid-scan is dropped
    load_pattern(vy);
    n = 0;
    while (n < FRAME_LAT + 1000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 250) frame_done_in = 1'b0;
      if (n == 500) begin
        check("pending.busy", busy, 1);
        check("pending.prev_held", pix_count, vx.cnt);
        frame_done_in = 1'b1;
      end
      if (result_valid) break;
    end
    check("pending.latency", n, FRAME_LAT);
    check_results(vy);
    repeat (200) @(negedge clk);
    check("drop.pulses", drop_cnt - drop_before, 1);
    check("drop.no_rescan_valid", rv_cnt - rv_before, 2);
    check("drop.no_rescan_busy", busy, 0);
    check("addr.range", addr_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
